noc_xbar_switch: RTL
====================

// Module: noc_xbar_switch
// PURPOSE
//  Parametrised NoC router crossbar: NPORTS inputs to NPORTS outputs, FLIT_W-bit flits.
//  Each output has a one-hot input select, a valid/ready handshake and a BUF_DEPTH output FIFO.
//  One input may feed several outputs at once (multicast). Illegal selects are flagged.
//  Sits between the router input VCs/allocator and the link drivers; port 0 is the local processor.
// PARAMETERS
//  NPORTS     5   port count; index 0=proc, 1=east, 2=south, 3=west, 4=north
//  FLIT_W     12  flit width in bits
//  BUF_DEPTH  2   entries per output FIFO; power of 2, >=2
//  CNT_W      16  width of each perf counter (used only with NOC_XBAR_PERF_EN)
// PORTS
//  clk       in   1               clock, rising edge
//  rst       in   1               asynchronous reset, active high
//  in_flit   in   NPORTS*FLIT_W   input flits; port i occupies [i*FLIT_W +: FLIT_W]
//  in_valid  in   NPORTS          input flit valid
//  in_ready  out  NPORTS          input flit accepted when valid&ready
//  sel_code  in   NPORTS*NPORTS   one-hot input select per output; output o is [o*NPORTS +: NPORTS]
//  out_flit  out  NPORTS*FLIT_W   head flit of each output FIFO
//  out_valid out  NPORTS          output FIFO non-empty
//  out_ready in   NPORTS          downstream accepts head flit
//  sel_err   out  NPORTS          sticky flag: illegal select seen on output o
//  perf_cnt  out  NPORTS*CNT_W    flits popped per output; all zeros without NOC_XBAR_PERF_EN
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): all FIFOs empty, out_valid=0, out_flit=0,
//    sel_err=0, perf_cnt=0. Reset during traffic drops all buffered flits.
//  - Select legality, output o: legal iff sel_code[o] is exactly one-hot and bit o is clear
//    (no U-turn). Illegal or zero means o is unconnected. Illegal nonzero also sets sel_err[o],
//    which is cleared only by reset.
//  - fanout(i) = set of legal outputs selecting input i.
//  - in_ready[i] = fanout(i) non-empty AND every output in fanout(i) has count<BUF_DEPTH.
//    Ready depends only on the registered count, never on same-cycle pop, so there is
//    no out_ready->in_ready combinational path.
//  - On in_valid[i]&in_ready[i], in_flit[i] is written to every FIFO in fanout(i) in the same edge.
//    The transfer is atomic: either all fanout FIFOs accept the flit or none do.
//  - Latency: a flit accepted at edge k appears on out_flit/out_valid after edge k (1 cycle).
//  - Pop: out_valid[o]&out_ready[o] at an edge advances the head.
//    Push and pop in the same cycle leave count unchanged, including when count=BUF_DEPTH.
//  - Empty: out_valid=0 and out_flit holds the last head value (0 after reset).
//  - Full: in_ready is low for every input selecting that output; other inputs are unaffected.
//  - FIFO read/write pointers wrap modulo BUF_DEPTH. count ranges 0..BUF_DEPTH.
//  - The allocator must hold sel_code stable while a packet is in flight.
//    A select change takes effect on the same cycle; the crossbar keeps no per-packet state.
// CONFIGURATION
//  NOC_XBAR_PERF_EN defined:
//    per-output CNT_W-bit counter, +1 on each pop, saturating at all-ones.
//  NOC_XBAR_PERF_EN undefined:
//    no counters are synthesised; perf_cnt is tied to 0.
// STRUCTURE
//  Package noc_xbar_pkg:
//    port index constants PORT_PROC..PORT_NORTH;
//    default NPORTS/FLIT_W/BUF_DEPTH/CNT_W;
//    function onehot_legal(sel, o).
//  Sub-module noc_xbar_obuf:
//    one FLIT_W x BUF_DEPTH FIFO with count, push, pop, valid and head;
//    instantiated NPORTS times by generate.
//  Top level: select decode, fanout and ready logic, sel_err flags, optional perf counters.
// TESTING
//  1 Unicast:
//    sel east=00001 (proc), proc valid flit 0x5A5, east out_ready=1.
//    -> in_ready[0]=1; east out_valid=1 with 0x5A5 one cycle later.
//  2 Backpressure:
//    east out_ready=0, proc sends 3 flits with BUF_DEPTH=2.
//    -> 2 accepted, then in_ready[0]=0.
//    Raise out_ready -> flits drain in order, and the 3rd is accepted after the first pop.
//  3 Multicast:
//    east and north both select south; south sends 0x123; north out_ready=0 with north full.
//    -> in_ready[2]=0 and no write to east. Free north -> both outputs get 0x123.
//  4 Illegal select:
//    west sel_code=00101, then east sel_code=00010 (U-turn).
//    -> west and east stay unconnected; sel_err=5'b01010 and held until rst.
//  5 Async reset mid-traffic:
//    assert rst between clock edges with FIFOs holding flits.
//    -> out_valid=0, out_flit=0, sel_err=0 immediately, without waiting for a clock edge.
//  6 PERF_EN:
//    CNT_W=4, 17 pops on proc output.
//    -> perf_cnt[proc]=4'hF (saturated).
//    Without the macro -> perf_cnt=0.

Source files
------------

// File: rtl/noc_xbar_pkg.sv
// Shared constants and helpers for the NoC crossbar switch.
// Port indices, default parameters and the select-legality check.
package noc_xbar_pkg;

    localparam int unsigned PORT_PROC  = 0;
    localparam int unsigned PORT_EAST  = 1;
    localparam int unsigned PORT_SOUTH = 2;
    localparam int unsigned PORT_WEST  = 3;
    localparam int unsigned PORT_NORTH = 4;

    localparam int unsigned NPORTS_DEF    = 5;
    localparam int unsigned FLIT_W_DEF    = 12;
    localparam int unsigned BUF_DEPTH_DEF = 2;
    localparam int unsigned CNT_W_DEF     = 16;

    // A select is legal when exactly one input is chosen and it is not the output itself.
    // Supports up to 32 ports; narrower selects are zero-extended by the caller.
    function automatic logic onehot_legal(logic [31:0] sel, int unsigned o);
        logic [31:0] sel_m1;
        sel_m1 = sel - 32'd1;
        return (sel != 32'd0) && ((sel & sel_m1) == 32'd0) && (((sel >> o) & 32'd1) == 32'd0);
    endfunction

endpackage

// File: rtl/noc_xbar_if.sv
// Crossbar data/handshake bundle: master is the traffic side (allocator, input VCs,
// link drivers), slave is the switch itself.
interface noc_xbar_if #(
    parameter int unsigned NPORTS = 5,
    parameter int unsigned FLIT_W = 12,
    parameter int unsigned CNT_W  = 16
);
    logic [NPORTS*FLIT_W-1:0] in_flit;
    logic [NPORTS-1:0]        in_valid;
    logic [NPORTS-1:0]        in_ready;
    logic [NPORTS*NPORTS-1:0] sel_code;
    logic [NPORTS*FLIT_W-1:0] out_flit;
    logic [NPORTS-1:0]        out_valid;
    logic [NPORTS-1:0]        out_ready;
    logic [NPORTS-1:0]        sel_err;
    logic [NPORTS*CNT_W-1:0]  perf_cnt;

    modport master (
        output in_flit, in_valid, sel_code, out_ready,
        input  in_ready, out_flit, out_valid, sel_err, perf_cnt
    );

    modport slave (
        input  in_flit, in_valid, sel_code, out_ready,
        output in_ready, out_flit, out_valid, sel_err, perf_cnt
    );
endinterface

// File: rtl/noc_xbar_obuf.sv
// One output FIFO of the crossbar: BUF_DEPTH entries, power-of-two pointer wrap.
// When empty the head output keeps showing the last popped flit (0 after reset).
module noc_xbar_obuf
    import noc_xbar_pkg::*;
#(
    parameter int unsigned FLIT_W    = FLIT_W_DEF,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [FLIT_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              valid_o,
    output logic [FLIT_W-1:0] head_o
);
    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    logic [FLIT_W-1:0] mem_q [BUF_DEPTH];
    logic [FLIT_W-1:0] mem_d [BUF_DEPTH];
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [FLIT_W-1:0] last_q, last_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q < CntW'(BUF_DEPTH)) || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        last_d  = last_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            last_d = mem_q[rptr_q];
            rptr_d = rptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        full_o  = (count_q == CntW'(BUF_DEPTH));
        valid_o = (count_q != '0);
        head_o  = valid_o ? mem_q[rptr_q] : last_q;
    end

endmodule

// File: rtl/noc_xbar_switch.sv
// NoC router crossbar: per-output one-hot input select with multicast, atomic fanout
// writes into per-output FIFOs. Optional pop counters under NOC_XBAR_PERF_EN.
module noc_xbar_switch
    import noc_xbar_pkg::*;
#(
    parameter int unsigned NPORTS    = NPORTS_DEF,
    parameter int unsigned FLIT_W    = FLIT_W_DEF,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic    clk,
    input  logic    rst,
    noc_xbar_if.slave bus
);
    logic [NPORTS-1:0] sel_vec [NPORTS];
    logic [NPORTS-1:0] conn    [NPORTS];  // conn[o][i]: output o is fed by input i
    logic [FLIT_W-1:0] wdata   [NPORTS];
    logic [FLIT_W-1:0] head    [NPORTS];
    logic [NPORTS-1:0] legal, full, push, valid, in_ready;
    logic [NPORTS-1:0] sel_err_q, sel_err_d;
    logic [NPORTS*FLIT_W-1:0] out_flit;

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            sel_vec[o] = bus.sel_code[o*NPORTS +: NPORTS];
            legal[o]   = onehot_legal(32'(sel_vec[o]), o);
            conn[o]    = legal[o] ? sel_vec[o] : '0;
        end
    end

    // Ready uses only registered fullness, so out_ready never reaches in_ready.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            logic has_fanout;
            logic blocked;
            has_fanout = 1'b0;
            blocked    = 1'b0;
            for (int o = 0; o < NPORTS; o++) begin
                if (conn[o][i]) begin
                    has_fanout = 1'b1;
                    if (full[o]) blocked = 1'b1;
                end
            end
            in_ready[i] = has_fanout && !blocked;
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            push[o]  = 1'b0;
            wdata[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (conn[o][i]) begin
                    push[o]  = bus.in_valid[i] && in_ready[i];
                    wdata[o] = bus.in_flit[i*FLIT_W +: FLIT_W];
                end
            end
        end
    end

    always_comb begin
        sel_err_d = sel_err_q;
        for (int o = 0; o < NPORTS; o++) begin
            if ((sel_vec[o] != '0) && !legal[o]) sel_err_d[o] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_q <= '0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_obuf
        noc_xbar_obuf #(
            .FLIT_W    (FLIT_W),
            .BUF_DEPTH (BUF_DEPTH)
        ) u_obuf (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[g]),
            .wdata_i (wdata[g]),
            .pop_i   (bus.out_ready[g]),
            .full_o  (full[g]),
            .valid_o (valid[g]),
            .head_o  (head[g])
        );
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            out_flit[o*FLIT_W +: FLIT_W] = head[o];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.out_flit  = out_flit;
    assign bus.sel_err   = sel_err_q;

`ifdef NOC_XBAR_PERF_EN
    logic [CNT_W-1:0]        cnt_q [NPORTS];
    logic [CNT_W-1:0]        cnt_d [NPORTS];
    logic [NPORTS*CNT_W-1:0] perf_cnt;

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            cnt_d[o] = cnt_q[o];
            if (valid[o] && bus.out_ready[o] && (cnt_q[o] != '1)) begin
                cnt_d[o] = cnt_q[o] + CNT_W'(1);
            end
            perf_cnt[o*CNT_W +: CNT_W] = cnt_q[o];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.perf_cnt = perf_cnt;
`else
    assign bus.perf_cnt = {(NPORTS*CNT_W){1'b0}};
`endif

endmodule
